simd_issue_sequencer: RTL and testbench
=======================================

// Module: simd_issue_sequencer
// PURPOSE
//  Per-warp instruction sequencer in front of the SIMD lane datapath. Fetches 32-bit instructions from
//  instruction memory, classifies the opcode, and issues one op at a time to the lanes with a
//  valid/ready handshake. Holds off fetch for multi-cycle MUL/UDIV and ends the warp on a return op.
//  Sits between the warp dispatcher (start/done) and the lane array plus instruction memory.
// PARAMETERS
//  PC_W     8  instruction address width, in words
//  MUL_LAT  3  lane cycles occupied by MUL after its issue handshake (>=1)
//  DIV_LAT  8  lane cycles occupied by UDIV after its issue handshake (>=1)
//  CNT_W    16 width of the retired-instruction counter
// PORTS
//  clk           in   1      clock
//  reset         in   1      synchronous, active-high reset
//  start         in   1      launch warp at base_pc; sampled only in IDLE
//  base_pc       in   PC_W   first instruction address
//  busy          out  1      high in every state other than IDLE
//  done          out  1      one-cycle pulse when the warp terminates
//  imem_req      out  1      one-cycle read strobe
//  imem_addr     out  PC_W   read address; valid while imem_req=1
//  imem_valid    in   1      read data valid; arrives >=1 cycle after imem_req
//  imem_rdata    in   32     instruction word
//  issue_valid   out  1      op presented to lanes
//  issue_ready   in   1      lanes accept op
//  issue_type    out  3      op class: 000 ADD, 001 SUB, 010 MUL, 011 UDIV, 100 FADD, 101 FSUB
//  issue_rn1     out  5      instr[9:5]
//  issue_rn2     out  5      instr[20:16]
//  issue_rd      out  5      instr[4:0]
//  issue_shamt   out  6      instr[15:10]
//  retired       out  CNT_W  ops issued in the current warp; cleared on start
//  stall_cycles  out  CNT_W  cycles spent in STALL (present only with the option; see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE; pc, retired, stall_cycles and every issue_* field are 0; busy, done, imem_req
//    and issue_valid are 0. Reset mid-warp abandons the warp with no done pulse.
//  - FSM states: IDLE, FETCH, WAIT_MEM, ISSUE, STALL, DONE.
//    IDLE: start=1 loads pc<=base_pc, clears retired and stall_cycles, and moves to FETCH.
//    FETCH: drives imem_req=1 and imem_addr=pc for exactly one cycle, then moves to WAIT_MEM.
//    WAIT_MEM: on imem_valid, latches the word and classifies it. Class 111 moves to DONE; any other
//      class moves to ISSUE. imem_valid seen outside WAIT_MEM is ignored.
//    ISSUE: issue_valid=1. issue_* fields stay stable until issue_valid && issue_ready.
//      On the handshake: pc<=pc+1, retired<=retired+1 (saturating). MUL moves to STALL with
//      cnt=MUL_LAT-1, UDIV moves to STALL with cnt=DIV_LAT-1, and every other class moves to FETCH.
//      If the loaded cnt is 0, the next state is FETCH directly.
//    STALL: decrements cnt each cycle; at cnt==0 moves to FETCH.
//    DONE: done=1 for one cycle, then moves to IDLE. busy drops in the same cycle the state enters IDLE.
//  - Classification uses instr[31:21]: 10001011000 ADD; 11001011000 SUB; 10011011000 MUL;
//    10011010110 UDIV. 00011110011 is FADD when instr[15:10]=001010 and FSUB when it is 001110.
//    Every other word is class 111 (return/terminate) and is never issued.
//  - pc wraps from 2^PC_W-1 to 0 with no error.
//  - start while busy is ignored. start and imem_valid together in IDLE: start wins and the data is dropped.
//  - Latency: start at cycle 0 gives imem_req at cycle 1. With one-cycle memory, issue_valid is at cycle 3.
// CONFIGURATION
//  SIMD_ISSUE_PERF_EN defined: stall_cycles increments (saturating) every cycle in STALL and every
//    cycle in ISSUE with issue_ready=0.
//  SIMD_ISSUE_PERF_EN undefined: the stall_cycles port still exists, is tied to 0, and has no
//    counter logic.
// STRUCTURE
//  Package simd_pkg: op_type_e (3-bit class enum incl. OP_RET=3'b111), 11-bit opcode constants, FP
//    sub-op constants, and the seq_state_e FSM enum.
//  Sub-module simd_op_classify (combinational): instr[31:0] -> op_type_e plus register/shamt fields.
//  Top level: FSM, pc, stall counter, retired counter, optional perf counter.
// TESTING
//  1 ADD,SUB,RET at base_pc=0x10, mem lat 1, ready=1 -> 2 issues (000, 001), retired=2, done pulses
//    once, imem_addr 0x10..0x12.
//  2 MUL then ADD, MUL_LAT=3 -> exactly 2 STALL cycles between the MUL handshake and the next imem_req.
//  3 ADD with issue_ready held 0 for 5 cycles -> issue_valid and fields stable for 6 cycles,
//    retired=1 after the handshake, stall_cycles=5 (PERF on).
//  4 Word 0x1E602800 (FADD) and 0x1E603800 (FSUB) -> issue_type 100 and 101; 0x1E601800 -> terminate,
//    not issued.
//  5 base_pc=0xFF, PC_W=8, ADD then RET -> second fetch at address 0x00.
//  6 reset asserted in STALL mid-UDIV -> next cycle IDLE, all outputs 0, no done; a new start runs normally.

Source files
------------

// File: rtl/simd_pkg.sv
// Shared types for the SIMD issue sequencer: op classes, opcode constants and FSM states.
package simd_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_UDIV = 3'b011,
    OP_FADD = 3'b100,
    OP_FSUB = 3'b101,
    OP_RET  = 3'b111
  } op_type_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_MEM,
    S_ISSUE,
    S_STALL,
    S_DONE
  } seq_state_e;

  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_MUL  = 11'b10011011000;
  localparam logic [10:0] OPC_UDIV = 11'b10011010110;
  localparam logic [10:0] OPC_FP   = 11'b00011110011;

  localparam logic [5:0] FP_SUBOP_ADD = 6'b001010;
  localparam logic [5:0] FP_SUBOP_SUB = 6'b001110;

endpackage

// File: rtl/simd_op_classify.sv
// Combinational decode of a 32-bit instruction word into op class and operand fields.
module simd_op_classify
  import simd_pkg::*;
(
  input  logic [31:0] instr_i,
  output op_type_e    type_o,
  output logic [4:0]  rn1_o,
  output logic [4:0]  rn2_o,
  output logic [4:0]  rd_o,
  output logic [5:0]  shamt_o
);

  assign rd_o    = instr_i[4:0];
  assign rn1_o   = instr_i[9:5];
  assign shamt_o = instr_i[15:10];
  assign rn2_o   = instr_i[20:16];

  // Anything unrecognised terminates the warp.
  always_comb begin
    type_o = OP_RET;
    case (instr_i[31:21])
      OPC_ADD:  type_o = OP_ADD;
      OPC_SUB:  type_o = OP_SUB;
      OPC_MUL:  type_o = OP_MUL;
      OPC_UDIV: type_o = OP_UDIV;
      OPC_FP: begin
        if (instr_i[15:10] == FP_SUBOP_ADD)      type_o = OP_FADD;
        else if (instr_i[15:10] == FP_SUBOP_SUB) type_o = OP_FSUB;
      end
      default: type_o = OP_RET;
    endcase
  end

endmodule

// File: rtl/simd_issue_sequencer.sv
// Per-warp fetch/classify/issue sequencer. Define SIMD_ISSUE_PERF_EN to enable the stall_cycles counter.
module simd_issue_sequencer
  import simd_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  base_pc,
  output logic             busy,
  output logic             done,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_valid,
  input  logic [31:0]      imem_rdata,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [2:0]       issue_type,
  output logic [4:0]       issue_rn1,
  output logic [4:0]       issue_rn2,
  output logic [4:0]       issue_rd,
  output logic [5:0]       issue_shamt,
  output logic [CNT_W-1:0] retired,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int LW      = $clog2(LAT_MAX + 1);
  localparam logic [LW-1:0] MUL_CNT = LW'(MUL_LAT - 1);
  localparam logic [LW-1:0] DIV_CNT = LW'(DIV_LAT - 1);

  seq_state_e       state_q;
  logic [PC_W-1:0]  pc_q;
  logic [CNT_W-1:0] retired_q;
  logic [LW-1:0]    cnt_q;
  op_type_e         type_q;
  logic [4:0]       rn1_q, rn2_q, rd_q;
  logic [5:0]       shamt_q;

  op_type_e   c_type;
  logic [4:0] c_rn1, c_rn2, c_rd;
  logic [5:0] c_shamt;

  simd_op_classify u_cls (
    .instr_i (imem_rdata),
    .type_o  (c_type),
    .rn1_o   (c_rn1),
    .rn2_o   (c_rn2),
    .rd_o    (c_rd),
    .shamt_o (c_shamt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      retired_q <= '0;
      cnt_q     <= '0;
      type_q    <= OP_ADD;
      rn1_q     <= '0;
      rn2_q     <= '0;
      rd_q      <= '0;
      shamt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          pc_q      <= base_pc;
          retired_q <= '0;
          state_q   <= S_FETCH;
        end
        S_FETCH: state_q <= S_WAIT_MEM;
        S_WAIT_MEM: if (imem_valid) begin
          type_q  <= c_type;
          rn1_q   <= c_rn1;
          rn2_q   <= c_rn2;
          rd_q    <= c_rd;
          shamt_q <= c_shamt;
          state_q <= (c_type == OP_RET) ? S_DONE : S_ISSUE;
        end
        S_ISSUE: if (issue_ready) begin
          pc_q <= pc_q + 1'b1;
          if (retired_q != '1) retired_q <= retired_q + 1'b1;
          if (type_q == OP_MUL) begin
            cnt_q   <= MUL_CNT;
            state_q <= (MUL_CNT == '0) ? S_FETCH : S_STALL;
          end else if (type_q == OP_UDIV) begin
            cnt_q   <= DIV_CNT;
            state_q <= (DIV_CNT == '0) ? S_FETCH : S_STALL;
          end else begin
            state_q <= S_FETCH;
          end
        end
        // Leave on the cycle the count reaches zero, so a load of N gives N stall cycles.
        S_STALL: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q <= LW'(1)) state_q <= S_FETCH;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign imem_req    = (state_q == S_FETCH);
  assign imem_addr   = pc_q;
  assign issue_valid = (state_q == S_ISSUE);
  assign issue_type  = type_q;
  assign issue_rn1   = rn1_q;
  assign issue_rn2   = rn2_q;
  assign issue_rd    = rd_q;
  assign issue_shamt = shamt_q;
  assign retired     = retired_q;

`ifdef SIMD_ISSUE_PERF_EN
  logic [CNT_W-1:0] stall_q;
  always_ff @(posedge clk) begin
    if (reset)                                                         stall_q <= '0;
    else if (state_q == S_IDLE && start)                               stall_q <= '0;
    else if ((state_q == S_STALL || (state_q == S_ISSUE && !issue_ready))
             && stall_q != '1)                                         stall_q <= stall_q + 1'b1;
  end
  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_simd_issue_sequencer.sv
// Directed bench for simd_issue_sequencer: memory responder, handshake monitor, hand-computed checks.
module tb_simd_issue_sequencer;
  import simd_pkg::*;

`ifdef SIMD_ISSUE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [31:0] W_ADD  = 32'h8B03_0041; // rd=1 rn1=2 rn2=3 shamt=0
  localparam logic [31:0] W_SUB  = 32'hCB0A_14C5; // rd=5 rn1=6 rn2=10 shamt=5
  localparam logic [31:0] W_MUL  = 32'h9B00_0000;
  localparam logic [31:0] W_UDIV = 32'h9AC0_0000;
  localparam logic [31:0] W_FADD = 32'h1E60_2800;
  localparam logic [31:0] W_FSUB = 32'h1E60_3800;
  localparam logic [31:0] W_FBAD = 32'h1E60_1800;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [7:0]  base_pc = '0;
  logic        busy, done, imem_req, imem_valid, issue_valid, issue_ready;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [2:0]  issue_type;
  logic [4:0]  issue_rn1, issue_rn2, issue_rd;
  logic [5:0]  issue_shamt;
  logic [15:0] retired, stall_cycles;

  simd_issue_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .base_pc(base_pc),
    .busy(busy), .done(done), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_type(issue_type),
    .issue_rn1(issue_rn1), .issue_rn2(issue_rn2), .issue_rd(issue_rd),
    .issue_shamt(issue_shamt), .retired(retired), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int n_run = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  logic [31:0] mem [256];
  int          mem_lat = 1;

  // Memory responder: data valid mem_lat cycles after the request cycle, for one cycle.
  initial begin
    logic [7:0] a;
    imem_valid = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (imem_req && !reset) begin
        a = imem_addr;
        repeat (mem_lat) begin @(posedge clk); #1; end
        imem_valid = 1'b1;
        imem_rdata = mem[a];
        @(posedge clk); #1;
        imem_valid = 1'b0;
      end
    end
  end

  int          cyc = 0, done_cnt = 0, iv_first = -1;
  logic [7:0]  req_q[$];
  int          req_c[$];
  logic [2:0]  typ_q[$];
  logic [20:0] fld_q[$];
  int          hs_c[$];

  initial forever begin
    @(negedge clk);
    cyc++;
    if (!reset) begin
      if (imem_req) begin req_q.push_back(imem_addr); req_c.push_back(cyc); end
      if (issue_valid && iv_first < 0) iv_first = cyc;
      if (issue_valid && issue_ready) begin
        typ_q.push_back(issue_type);
        fld_q.push_back({issue_rd, issue_rn1, issue_rn2, issue_shamt});
        hs_c.push_back(cyc);
      end
      if (done) done_cnt++;
    end
  end

  int s0;

  task automatic clr();
    req_q.delete(); req_c.delete(); typ_q.delete(); fld_q.delete(); hs_c.delete();
    done_cnt = 0;
    iv_first = -1;
  endtask

  task automatic kick(input logic [7:0] base);
    clr();
    @(posedge clk); #1;
    base_pc = base;
    start   = 1'b1;
    s0      = cyc + 1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 300) begin @(posedge clk); #1; n++; end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_done"}, done_cnt, 1);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int stable;
    logic [23:0] snap;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    issue_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ctl", {done, imem_req, issue_valid}, 0);
    chk("rst_flds", {issue_type, issue_rd, issue_rn1, issue_rn2, issue_shamt}, 0);
    chk("rst_cnt", {retired, stall_cycles}, 0);
    reset = 1'b0;

    // 1: ADD, SUB, RET
    mem[8'h10] = W_ADD; mem[8'h11] = W_SUB; mem[8'h12] = 32'h0;
    mem_lat = 1;
    kick(8'h10);
    wait_done("t1");
    chk("t1_req_lat", req_c[0] - s0, 1);
    chk("t1_iv_lat", iv_first - s0, 3);
    chk("t1_nreq", req_q.size(), 3);
    chk("t1_addr", {req_q[0], req_q[1], req_q[2]}, 24'h101112);
    chk("t1_nis", typ_q.size(), 2);
    chk("t1_types", {typ_q[0], typ_q[1]}, 6'b000_001);
    chk("t1_add_f", fld_q[0], {5'd1, 5'd2, 5'd3, 6'd0});
    chk("t1_sub_f", fld_q[1], {5'd5, 5'd6, 5'd10, 6'd5});
    chk("t1_ret", retired, 2);

    // 2: MUL then ADD
    mem[8'h20] = W_MUL; mem[8'h21] = W_ADD; mem[8'h22] = 32'h0;
    kick(8'h20);
    wait_done("t2");
    chk("t2_types", {typ_q[0], typ_q[1]}, 6'b010_000);
    chk("t2_mul_gap", req_c[1] - hs_c[0], 3);
    chk("t2_add_gap", req_c[2] - hs_c[1], 1);
    chk("t2_ret", retired, 2);
    chk("t2_stall", stall_cycles, PERF ? 2 : 0);

    // 3: ADD held off by issue_ready=0 for 5 cycles
    mem[8'h28] = W_ADD; mem[8'h29] = 32'h0;
    issue_ready = 1'b0;
    kick(8'h28);
    begin
      int n;
      n = 0;
      while (!issue_valid && n < 50) begin @(posedge clk); #1; n++; end
    end
    snap   = {issue_type, issue_rd, issue_rn1, issue_rn2, issue_shamt};
    stable = 0;
    for (int i = 0; i < 6; i++) begin
      if (issue_valid && {issue_type, issue_rd, issue_rn1, issue_rn2, issue_shamt} == snap)
        stable++;
      if (i == 5) issue_ready = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("t3_snap", snap, {3'b000, 5'd1, 5'd2, 5'd3, 6'd0});
    chk("t3_stable", stable, 6);
    @(posedge clk); #1;
    chk("t3_ret", retired, 1);
    chk("t3_stall", stall_cycles, PERF ? 5 : 0);
    wait_done("t3");

    // 4: FADD, FSUB, then an unknown FP sub-op terminates; two-cycle memory
    mem[8'h30] = W_FADD; mem[8'h31] = W_FSUB; mem[8'h32] = W_FBAD;
    mem_lat = 2;
    kick(8'h30);
    wait_done("t4");
    chk("t4_nis", typ_q.size(), 2);
    chk("t4_types", {typ_q[0], typ_q[1]}, 6'b100_101);
    chk("t4_nreq", req_q.size(), 3);
    chk("t4_ret", retired, 2);

    // 5: pc wrap
    mem[8'hFF] = W_ADD; mem[8'h00] = 32'h0;
    mem_lat = 1;
    kick(8'hFF);
    wait_done("t5");
    chk("t5_addr", {req_q[0], req_q[1]}, 16'hFF00);
    chk("t5_ret", retired, 1);

    // 6: reset in STALL mid-UDIV, then a normal warp
    mem[8'h40] = W_UDIV; mem[8'h41] = 32'h0;
    kick(8'h40);
    begin
      int n;
      n = 0;
      while (hs_c.size() == 0 && n < 50) begin @(posedge clk); #1; n++; end
    end
    chk("t6_udiv", typ_q[0], 3'b011);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t6_busy", busy, 0);
    chk("t6_ctl", {done, imem_req, issue_valid}, 0);
    chk("t6_flds", {issue_type, issue_rd, issue_rn1, issue_rn2, issue_shamt}, 0);
    chk("t6_cnt", {retired, stall_cycles}, 0);
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("t6_nodone", done_cnt, 0);
    chk("t6_idle", {busy, imem_req}, 0);
    kick(8'h10);
    wait_done("t6b");
    chk("t6b_types", {typ_q[0], typ_q[1]}, 6'b000_001);
    chk("t6b_ret", retired, 2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
